systolic_feeder: RTL and testbench

- Transmit-side driver for the 2-D systolic GEMM tile.
- Accepts one K-step per handshake beat: a column of A (ROWS values) and a row of B (COLS values).
- Applies diagonal skew (row i delayed i cycles, column j delayed j cycles) and drives the array's a_in/b_in/valid_in/clear_all.
- Sequences clear, feed and flush, then pulses done when every accumulator holds the final C = A·B.

---
 rtl/systolic_feeder.sv | 164 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - diagonal-skew feeder sequencing clear/feed/flush for a 2-D systolic GEMM tile
// Optional abort/aborted ports are enabled by defining SYSTOLIC_FEEDER_ABORT_EN.

module systolic_feeder #(
   parameter int ROWS     = 16,
   parameter int COLS     = 16,
   parameter int DATA_W_P = 16,
   parameter int K_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [K_W-1:0]             k_len,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [DATA_W_P-1:0] a_col [ROWS],
   input  logic signed [DATA_W_P-1:0] b_row [COLS],
   output logic signed [DATA_W_P-1:0] a_in [ROWS],
   output logic signed [DATA_W_P-1:0] b_in [COLS],
   output logic                       valid_in,
   output logic                       clear_all,
   output logic                       busy,
`ifdef SYSTOLIC_FEEDER_ABORT_EN
   input  logic                       abort,
   output logic                       aborted,
`endif
   output logic                       done
);

   localparam int FLUSH_LEN = ROWS + COLS - 1;
   localparam int F_W       = $clog2(FLUSH_LEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH} state_e;

   state_e         state_q, state_d;
   logic [K_W-1:0] klen_q, klen_d;
   logic [K_W-1:0] kcnt_q, kcnt_d;
   logic [F_W-1:0] fcnt_q, fcnt_d;
   logic           done_q, done_d;
   logic           accept;
   logic           abort_hit;

   assign accept = (state_q == S_FEED) && in_valid;

`ifdef SYSTOLIC_FEEDER_ABORT_EN
   logic aborted_q;

   assign abort_hit = abort && (state_q != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aborted_q <= 1'b0;
      end else begin
         aborted_q <= abort_hit;
      end
   end

   assign aborted = aborted_q;
`else
   assign abort_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         klen_q  <= '0;
         kcnt_q  <= '0;
         fcnt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         klen_q  <= klen_d;
         kcnt_q  <= kcnt_d;
         fcnt_q  <= fcnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      klen_d  = klen_q;
      kcnt_d  = kcnt_q;
      fcnt_d  = fcnt_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A zero-length tile completes without touching the array.
            if (start) begin
               if (k_len != '0) begin
                  state_d = S_CLEAR;
                  klen_d  = k_len;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            state_d = S_FEED;
            kcnt_d  = '0;
         end
         S_FEED: begin
            if (in_valid) begin
               kcnt_d = kcnt_q + K_W'(1);
               if (kcnt_q == klen_q - K_W'(1)) begin
                  state_d = S_FLUSH;
                  fcnt_d  = '0;
               end
            end
         end
         S_FLUSH: begin
            fcnt_d = fcnt_q + F_W'(1);
            if (fcnt_q == F_W'(FLUSH_LEN - 1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_hit) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end
   end

   always_comb begin
      in_ready  = (state_q == S_FEED);
      valid_in  = (state_q == S_FEED) || (state_q == S_FLUSH);
      clear_all = (state_q == S_CLEAR);
      busy      = (state_q != S_IDLE);
      done      = done_q;
   end

   // Lane i is a chain of i+1 registers; zeros enter whenever no beat is accepted.
   for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
      logic signed [DATA_W_P-1:0] chain_q [i+1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int m = 0; m <= i; m++) chain_q[m] <= '0;
         end else begin
            chain_q[0] <= (accept && !abort_hit) ? a_col[i] : '0;
            for (int m = 1; m <= i; m++) chain_q[m] <= abort_hit ? '0 : chain_q[m-1];
         end
      end

      assign a_in[i] = chain_q[i];
   end

   for (genvar j = 0; j < COLS; j++) begin : g_b_lane
      logic signed [DATA_W_P-1:0] chain_q [j+1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int m = 0; m <= j; m++) chain_q[m] <= '0;
         end else begin
            chain_q[0] <= (accept && !abort_hit) ? b_row[j] : '0;
            for (int m = 1; m <= j; m++) chain_q[m] <= abort_hit ? '0 : chain_q[m-1];
         end
      end

      assign b_in[j] = chain_q[j];
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder driving a behavioural 4x4 PE array

module tb_systolic_feeder;

   localparam int R  = 4;
   localparam int C  = 4;
   localparam int DW = 16;
   localparam int KW = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic [KW-1:0]        k_len;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] a_col [R];
   logic signed [DW-1:0] b_row [C];
   logic signed [DW-1:0] a_in [R];
   logic signed [DW-1:0] b_in [C];
   logic                 valid_in;
   logic                 clear_all;
   logic                 busy;
   logic                 done;
`ifdef SYSTOLIC_FEEDER_ABORT_EN
   logic                 abort;
   logic                 aborted;
`endif

   always #5 clk = ~clk;

   systolic_feeder #(.ROWS(R), .COLS(C), .DATA_W_P(DW), .K_W(KW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k_len     (k_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_col     (a_col),
      .b_row     (b_row),
      .a_in      (a_in),
      .b_in      (b_in),
      .valid_in  (valid_in),
      .clear_all (clear_all),
      .busy      (busy),
`ifdef SYSTOLIC_FEEDER_ABORT_EN
      .abort     (abort),
      .aborted   (aborted),
`endif
      .done      (done)
   );

   typedef struct {
      bit zero_k;
      int lat;
      int row_sum [R];
   } exp_t;

   exp_t exp_q [$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural output-stationary array: a moves right, b moves down, acc += a*b.
   int pa [R][C];
   int pb [R][C];
   int acc [R][C];
   int clear_cyc, start_cyc, n_clears;
   int a0_cyc, a0_val, a3_cyc, a3_val, b0_cyc, b3_cyc;

   initial begin : monitor
      exp_t e;
      int   al, bt;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            n_clears = 0; clear_cyc = 0; start_cyc = 0;
            for (int i = 0; i < R; i++)
               for (int j = 0; j < C; j++) begin
                  pa[i][j] = 0; pb[i][j] = 0; acc[i][j] = 0;
               end
         end else begin
            if (start && !busy) start_cyc = cyc;
            if (done) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  if (e.zero_k) begin
                     check("k0_done_latency", cyc - start_cyc, 1);
                     check("k0_clear_pulses", n_clears, 0);
                  end else begin
                     check("done_latency", cyc - clear_cyc, e.lat);
                     check("clear_pulses", n_clears, 1);
                     check("a0_first_value", a0_val, 1);
                     check("a_skew_cycles", a3_cyc - a0_cyc, R - 1);
                     check("a3_first_value", a3_val, R);
                     check("b_skew_cycles", b3_cyc - b0_cyc, C - 1);
                     for (int i = 0; i < R; i++)
                        for (int j = 0; j < C; j++)
                           check($sformatf("C[%0d][%0d]", i, j), acc[i][j], e.row_sum[i]);
                  end
               end
               n_clears = 0;
            end
`ifdef SYSTOLIC_FEEDER_ABORT_EN
            if (aborted) n_clears = 0;
`endif
            if (clear_all) begin
               n_clears++;
               clear_cyc = cyc;
               a0_cyc = -1; a3_cyc = -1; b0_cyc = -1; b3_cyc = -1;
               for (int i = 0; i < R; i++)
                  for (int j = 0; j < C; j++) begin
                     pa[i][j] = 0; pb[i][j] = 0; acc[i][j] = 0;
                  end
            end else if (valid_in) begin
               if (a0_cyc < 0 && a_in[0] != 0) begin a0_cyc = cyc; a0_val = int'(a_in[0]); end
               if (a3_cyc < 0 && a_in[R-1] != 0) begin a3_cyc = cyc; a3_val = int'(a_in[R-1]); end
               if (b0_cyc < 0 && b_in[0] != 0) b0_cyc = cyc;
               if (b3_cyc < 0 && b_in[C-1] != 0) b3_cyc = cyc;
               for (int i = R - 1; i >= 0; i--)
                  for (int j = C - 1; j >= 0; j--) begin
                     al = (j == 0) ? int'(a_in[i]) : pa[i][j-1];
                     bt = (i == 0) ? int'(b_in[j]) : pb[i-1][j];
                     acc[i][j] += al * bt;
                     pa[i][j] = al;
                     pb[i][j] = bt;
                  end
            end
         end
      end
   end

   // Beat k carries A(:,k) = {1,2,3,4} + 4k and B(k,:) = all ones.
   task automatic send_beat(input int k);
      int t = 0;
      in_valid = 1'b1;
      for (int i = 0; i < R; i++) a_col[i] = DW'(i + 1 + 4 * k);
      for (int j = 0; j < C; j++) b_row[j] = DW'(1);
      @(negedge clk);
      while (!in_ready && t < 100) begin
         t++;
         @(negedge clk);
      end
      check("beat_accepted", int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < R; i++) a_col[i] = '0;
      for (int j = 0; j < C; j++) b_row[j] = '0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      check("tile_completed", exp_q.size(), 0);
      #1;
   endtask

   task automatic run_tile(input int gap, input bit restart);
      exp_t e;
      e.zero_k  = 1'b0;
      e.lat     = 11 + gap;
      e.row_sum = '{15, 18, 21, 24};
      exp_q.push_back(e);
      start = 1'b1;
      k_len = KW'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 1 && gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
         if (k == 1 && restart) begin
            start = 1'b1;
            k_len = KW'(5);
         end
         send_beat(k);
         if (k == 1 && restart) start = 1'b0;
      end
      wait_drain();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : stimulus
      exp_t e;
      rst_n    = 1'b0;
      start    = 1'b0;
      k_len    = '0;
      in_valid = 1'b0;
      for (int i = 0; i < R; i++) a_col[i] = '0;
      for (int j = 0; j < C; j++) b_row[j] = '0;
`ifdef SYSTOLIC_FEEDER_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", int'(in_ready), 0);
      check("reset_valid_in", int'(valid_in), 0);
      check("reset_clear_all", int'(clear_all), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      for (int i = 0; i < R; i++) check($sformatf("reset_a_in[%0d]", i), int'(a_in[i]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_tile(0, 1'b0);
      run_tile(2, 1'b0);

      e.zero_k  = 1'b1;
      e.lat     = 1;
      e.row_sum = '{0, 0, 0, 0};
      exp_q.push_back(e);
      start = 1'b1;
      k_len = '0;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("k0_busy", int'(busy), 0);
      check("k0_done_pulse", int'(done), 1);
      wait_drain();

      run_tile(0, 1'b1);

      start = 1'b1;
      k_len = KW'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) send_beat(k);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < R; i++) check($sformatf("rst_flush_a_in[%0d]", i), int'(a_in[i]), 0);
      for (int j = 0; j < C; j++) check($sformatf("rst_flush_b_in[%0d]", j), int'(b_in[j]), 0);
      check("rst_flush_valid_in", int'(valid_in), 0);
      check("rst_flush_busy", int'(busy), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("rst_flush_no_done", int'(done), 0);
      end
      @(posedge clk);
      #1;
      run_tile(0, 1'b0);

`ifdef SYSTOLIC_FEEDER_ABORT_EN
      start = 1'b1;
      k_len = KW'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
      send_beat(0);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_pulse", int'(aborted), 1);
      check("abort_valid_in", int'(valid_in), 0);
      check("abort_in_ready", int'(in_ready), 0);
      for (int i = 0; i < R; i++) check($sformatf("abort_a_in[%0d]", i), int'(a_in[i]), 0);
      @(posedge clk);
      #1;
      check("abort_single_pulse", int'(aborted), 0);
      repeat (20) begin
         @(negedge clk);
         check("abort_no_done", int'(done), 0);
      end
      @(posedge clk);
      #1;
      run_tile(0, 1'b0);
`endif

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
